cbus_rr_arbiter: RTL

Round-robin arbiter that shares the single cached-bus (cbus) port to the memory model (`RAMHelper2` in simulation, the SoC AXI bridge on board) among `NREQ` cbus requesters, typically the instruction-cache and data-cache refill/writeback engines inside `VTop`. It grants one requester at a time for a whole transaction (single beat or burst) and routes the response back to that requester only. It counts beats against the requested burst length and flags protocol errors.

---
 rtl/cbus_rr_arbiter.sv | 133 +++++++++++++
 1 files changed

// File: rtl/cbus_rr_arbiter.sv
// Cached-bus types plus a round-robin arbiter that hands the single memory-side
// cbus port to one requester per transaction and routes the response back to it.
package cbus_pkg;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [3:0]  strobe;
        logic [31:0] data;
        logic [3:0]  len;
        logic [1:0]  burst;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] data;
    } cbus_resp_t;

endpackage

module cbus_rr_arbiter
    import cbus_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDXW = $clog2(NREQ)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  cbus_req_t  [NREQ-1:0]  ireqs,
    output cbus_resp_t [NREQ-1:0]  iresps,
    output cbus_req_t              oreq,
    input  cbus_resp_t             oresp,
    output logic [IDXW-1:0]        grant_idx,
    output logic                   busy,
    output logic                   proto_err
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0]      state;
    logic [IDXW-1:0] owner;
    logic [IDXW-1:0] ptr;
    logic [IDXW-1:0] next_ptr;
    logic [IDXW-1:0] pick;
    logic [IDXW-1:0] cand;
    logic            pick_hit;
    logic [3:0]      beat;
    logic            err;
    logic            finish;
    cbus_req_t       cur;

    assign cur       = ireqs[owner];
    assign next_ptr  = (owner == IDXW'(NREQ - 1)) ? '0 : owner + 1'b1;
    assign busy      = (state == BUSY);
    assign grant_idx = owner;

    // First valid requester at or after ptr, wrapping at NREQ.
    always_comb begin
        pick     = '0;
        cand     = '0;
        pick_hit = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = IDXW'((32'(ptr) + i) % NREQ);
            if (!pick_hit && ireqs[cand].valid) begin
                pick     = cand;
                pick_hit = 1'b1;
            end
        end
    end

    always_comb begin
        err    = 1'b0;
        finish = 1'b0;
        if (state == BUSY) begin
            if (!cur.valid) begin
                err    = 1'b1;
                finish = 1'b1;
            end else if (oresp.ready) begin
                if (oresp.last && beat != cur.len)
                    err = 1'b1;
                if (!oresp.last && beat == cur.len)
                    err = 1'b1;
                finish = oresp.last;
            end
        end
    end

    // An aborting owner (valid dropped) gets no response forwarded.
    always_comb begin
        oreq   = '0;
        iresps = '0;
        if (state == BUSY) begin
            oreq = cur;
            if (cur.valid)
                iresps[owner] = oresp;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            owner     <= '0;
            ptr       <= '0;
            beat      <= '0;
            proto_err <= 1'b0;
        end else begin
            proto_err <= err;
            case (state)
                IDLE: begin
                    if (pick_hit) begin
                        owner <= pick;
                        beat  <= '0;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (finish) begin
                        state <= IDLE;
                        ptr   <= next_ptr;
                    end else if (oresp.ready) begin
                        beat <= beat + 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
